// File: rtl/aes_pkg.sv
// Shared AES types and GF(2^8)/S-box/key-schedule helpers for the inverse cipher.
package aes_pkg;

   localparam int unsigned RC_W = 4;

   typedef enum logic [1:0] {IDLE, KEXP, ROUND, DONE} state_e;

   function automatic logic [7:0] rcon(input logic [RC_W-1:0] rc);
      case (rc)
         4'd1:    return 8'h01;
         4'd2:    return 8'h02;
         4'd3:    return 8'h04;
         4'd4:    return 8'h08;
         4'd5:    return 8'h10;
         4'd6:    return 8'h20;
         4'd7:    return 8'h40;
         4'd8:    return 8'h80;
         4'd9:    return 8'h1b;
         4'd10:   return 8'h36;
         default: return 8'h00;
      endcase
   endfunction

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] aa;
      p  = '0;
      aa = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ aa;
         aa = xtime(aa);
      end
      return p;
   endfunction

   function automatic logic [7:0] mul_x9(input logic [7:0] b);
      return xtime(xtime(xtime(b))) ^ b;
   endfunction

   function automatic logic [7:0] mul_xb(input logic [7:0] b);
      return xtime(xtime(xtime(b))) ^ xtime(b) ^ b;
   endfunction

   function automatic logic [7:0] mul_xd(input logic [7:0] b);
      return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ b;
   endfunction

   function automatic logic [7:0] mul_xe(input logic [7:0] b);
      return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ xtime(b);
   endfunction

   // Multiplicative inverse as a^254 (maps 0 to 0)
   function automatic logic [7:0] gf_inv(input logic [7:0] a);
      logic [7:0] a2, a3, a12, a15, a240;
      a2   = gf_mul(a, a);
      a3   = gf_mul(a2, a);
      a12  = gf_mul(gf_mul(a3, a3), gf_mul(a3, a3));
      a15  = gf_mul(a12, a3);
      a240 = gf_mul(a15, a15);
      a240 = gf_mul(a240, a240);
      a240 = gf_mul(a240, a240);
      a240 = gf_mul(a240, a240);
      return gf_mul(gf_mul(a240, a12), a2);
   endfunction

   function automatic logic [7:0] sbox(input logic [7:0] b);
      logic [7:0] v;
      v = gf_inv(b);
      return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
   endfunction

   function automatic logic [7:0] inv_sbox(input logic [7:0] b);
      return gf_inv({b[6:0], b[7]} ^ {b[4:0], b[7:5]} ^ {b[1:0], b[7:2]} ^ 8'h05);
   endfunction

   function automatic logic [31:0] sub_word(input logic [31:0] w);
      return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
   endfunction

   function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
      logic [7:0] a0, a1, a2, a3;
      {a0, a1, a2, a3} = col;
      return {mul_xe(a0) ^ mul_xb(a1) ^ mul_xd(a2) ^ mul_x9(a3),
              mul_x9(a0) ^ mul_xe(a1) ^ mul_xb(a2) ^ mul_xd(a3),
              mul_xd(a0) ^ mul_x9(a1) ^ mul_xe(a2) ^ mul_xb(a3),
              mul_xb(a0) ^ mul_xd(a1) ^ mul_x9(a2) ^ mul_xe(a3)};
   endfunction

   // Forward schedule step: rk[rc-1] -> rk[rc]
   function automatic logic [127:0] key_gen(input logic [RC_W-1:0] rc, input logic [127:0] kin);
      logic [31:0] t, n0, n1, n2, n3;
      t  = sub_word({kin[23:0], kin[31:24]}) ^ {rcon(rc), 24'h0};
      n0 = kin[127:96] ^ t;
      n1 = kin[95:64] ^ n0;
      n2 = kin[63:32] ^ n1;
      n3 = kin[31:0] ^ n2;
      return {n0, n1, n2, n3};
   endfunction

   // Backward schedule step: rk[rc] -> rk[rc-1]
   function automatic logic [127:0] inv_key_gen(input logic [RC_W-1:0] rc, input logic [127:0] kin);
      logic [31:0] w0, w1, w2, w3;
      w3 = kin[31:0] ^ kin[63:32];
      w2 = kin[63:32] ^ kin[95:64];
      w1 = kin[95:64] ^ kin[127:96];
      w0 = kin[127:96] ^ sub_word({w3[23:0], w3[31:24]}) ^ {rcon(rc), 24'h0};
      return {w0, w1, w2, w3};
   endfunction

endpackage

// File: rtl/aes_inv_round.sv
// One combinational AES inverse round; the last round skips InvMixColumns.
module aes_inv_round
   import aes_pkg::*;
(
   input  logic [127:0] i_state,
   input  logic [127:0] i_rk,
   input  logic         i_last,
   output logic [127:0] o_state
);

   logic [127:0] w_t;
   logic [127:0] w_mix;

   // InvShiftRows, InvSubBytes and AddRoundKey; byte (r,c) sits at index 4c+r
   always_comb begin
      w_t = '0;
      for (int c = 0; c < 4; c++) begin
         for (int r = 0; r < 4; r++) begin
            w_t[127-8*(4*c+r) -: 8] = inv_sbox(i_state[127-8*(4*((c-r+4)%4)+r) -: 8])
                                      ^ i_rk[127-8*(4*c+r) -: 8];
         end
      end
   end

   // InvMixColumns on each column
   always_comb begin
      w_mix = '0;
      for (int c = 0; c < 4; c++) begin
         w_mix[127-32*c -: 32] = inv_mix_col(w_t[127-32*c -: 32]);
      end
   end

   assign o_state = i_last ? w_t : w_mix;

endmodule

// File: rtl/aes_inv_cipher_iter.sv
// Iterative AES-128 decryption: 10 forward key-schedule cycles, then 10 inverse rounds.
module aes_inv_cipher_iter
   import aes_pkg::*;
#(
   parameter int unsigned NR = 10
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [127:0] key,
   input  logic [127:0] ct,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [127:0] pt,
   output logic         busy
);

   localparam logic [RC_W-1:0] RC_LAST = RC_W'(NR);
   localparam logic [RC_W-1:0] RC_ONE  = RC_W'(1);

   state_e          r_fsm;
   state_e          w_fsm_nxt;
   logic [RC_W-1:0] r_rc;
   logic [127:0]    r_key;
   logic [127:0]    r_blk;
   logic [127:0]    r_pt;
   logic [127:0]    w_key_fwd;
   logic [127:0]    w_key_inv;
   logic [127:0]    w_round_out;
   logic            w_rc_ok;
   logic            w_last;

   assign w_rc_ok   = (r_rc >= RC_ONE) && (r_rc <= RC_LAST);
   assign w_last    = (r_rc == RC_ONE);
   assign w_key_fwd = key_gen(r_rc, r_key);
   assign w_key_inv = inv_key_gen(r_rc, r_key);

   aes_inv_round u_round (
      .i_state (r_blk),
      .i_rk    (w_key_inv),
      .i_last  (w_last),
      .o_state (w_round_out)
   );

   // FSM state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_fsm <= IDLE;
      else        r_fsm <= w_fsm_nxt;
   end

   // Next-state logic; an out-of-range round counter drops back to IDLE
   always_comb begin
      w_fsm_nxt = r_fsm;
      case (r_fsm)
         IDLE:  if (in_valid) w_fsm_nxt = KEXP;
         KEXP: begin
            if (!w_rc_ok)             w_fsm_nxt = IDLE;
            else if (r_rc == RC_LAST) w_fsm_nxt = ROUND;
         end
         ROUND: begin
            if (!w_rc_ok)    w_fsm_nxt = IDLE;
            else if (w_last) w_fsm_nxt = DONE;
         end
         DONE:  if (out_ready) w_fsm_nxt = IDLE;
         default: w_fsm_nxt = IDLE;
      endcase
   end

   // Status outputs decoded from the state register
   always_comb begin
      in_ready  = 1'b0;
      busy      = 1'b0;
      out_valid = 1'b0;
      case (r_fsm)
         IDLE:    in_ready  = 1'b1;
         KEXP:    busy      = 1'b1;
         ROUND:   busy      = 1'b1;
         DONE:    out_valid = 1'b1;
         default: in_ready  = 1'b0;
      endcase
   end

   // Datapath: round counter, rolling round key, block state and plaintext
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rc  <= '0;
         r_key <= '0;
         r_blk <= '0;
         r_pt  <= '0;
      end else begin
         case (r_fsm)
            IDLE: begin
               if (in_valid) begin
                  r_key <= key;
                  r_blk <= ct;
                  r_rc  <= RC_ONE;
               end
            end
            KEXP: begin
               r_key <= w_key_fwd;
               if (r_rc == RC_LAST) r_blk <= r_blk ^ w_key_fwd;
               else                 r_rc  <= r_rc + RC_ONE;
            end
            ROUND: begin
               r_key <= w_key_inv;
               r_blk <= w_round_out;
               r_rc  <= r_rc - RC_ONE;
               if (w_last) r_pt <= w_round_out;
            end
            default: ;
         endcase
      end
   end

   assign pt = r_pt;

endmodule

// File: tb/tb_aes_inv_cipher_iter.sv
// Scoreboard bench for aes_inv_cipher_iter with a byte-array AES reference model.
module tb_aes_inv_cipher_iter;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         in_valid;
   logic         in_ready;
   logic [127:0] key;
   logic [127:0] ct;
   logic         out_valid;
   logic         out_ready = 1'b0;
   logic [127:0] pt;
   logic         busy;

   aes_inv_cipher_iter #(.NR(10)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .key       (key),
      .ct        (ct),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .pt        (pt),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;
   int cyc      = 0;

   logic [127:0] exp_q[$];
   int           acc_q[$];
   int           acc_hist[$];

   bit   rdy_rand = 1'b0;
   logic rdy_val  = 1'b1;

   logic [7:0] sb  [256];
   logic [7:0] isb [256];

   localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] P1 = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] K2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] C2 = 128'h3925841d02dc09fbdc118597196a0b32;
   localparam logic [127:0] P2 = 128'h3243f6a8885a308d313198a2e0370734;
   localparam logic [127:0] C3 = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", nm, act, exp);
   endtask

   task automatic tmo(input string nm);
      n_checks++;
      $display("FAIL %s: timed out waiting on DUT", nm);
   endtask

   // S-box built by walking the generator 3 and its inverse
   task automatic build_tables();
      logic [7:0] p, q, x;
      p = 8'h01;
      q = 8'h01;
      do begin
         p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
         q = q ^ {q[6:0], 1'b0};
         q = q ^ {q[5:0], 2'b0};
         q = q ^ {q[3:0], 4'b0};
         if (q[7]) q = q ^ 8'h09;
         x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
         sb[p] = x ^ 8'h63;
      end while (p != 8'h01);
      sb[0] = 8'h63;
      for (int i = 0; i < 256; i++) isb[sb[i]] = 8'(i);
   endtask

   function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] r, aa;
      r  = 8'h00;
      aa = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) r = r ^ aa;
         aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
      end
      return r;
   endfunction

   // Textbook inverse cipher over a fully expanded 176-byte key schedule
   function automatic logic [127:0] ref_decrypt(input logic [127:0] k, input logic [127:0] c);
      logic [7:0] w [176];
      logic [7:0] s [16];
      logic [7:0] ns [16];
      logic [7:0] t [4];
      logic [7:0] m [4];
      logic [7:0] rcv, tmp, acc;
      logic [127:0] res;
      m[0] = 8'h0e; m[1] = 8'h0b; m[2] = 8'h0d; m[3] = 8'h09;
      for (int i = 0; i < 16; i++) w[i] = k[127-8*i -: 8];
      rcv = 8'h01;
      for (int i = 16; i < 176; i += 4) begin
         for (int j = 0; j < 4; j++) t[j] = w[i-4+j];
         if (i % 16 == 0) begin
            tmp = t[0];
            t[0] = sb[t[1]] ^ rcv;
            t[1] = sb[t[2]];
            t[2] = sb[t[3]];
            t[3] = sb[tmp];
            rcv = gm(rcv, 8'h02);
         end
         for (int j = 0; j < 4; j++) w[i+j] = w[i-16+j] ^ t[j];
      end
      for (int i = 0; i < 16; i++) s[i] = c[127-8*i -: 8] ^ w[160+i];
      for (int rnd = 9; rnd >= 0; rnd--) begin
         for (int cc = 0; cc < 4; cc++)
            for (int r = 0; r < 4; r++)
               ns[4*((cc+r)%4)+r] = s[4*cc+r];
         for (int i = 0; i < 16; i++) s[i] = isb[ns[i]] ^ w[16*rnd+i];
         if (rnd > 0) begin
            for (int cc = 0; cc < 4; cc++)
               for (int r = 0; r < 4; r++) begin
                  acc = 8'h00;
                  for (int j = 0; j < 4; j++) acc = acc ^ gm(m[(j-r+4)%4], s[4*cc+j]);
                  ns[4*cc+r] = acc;
               end
            for (int i = 0; i < 16; i++) s[i] = ns[i];
         end
      end
      for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
      return res;
   endfunction

   always @(posedge clk) cyc <= cyc + 1;

   // Consumer-side ready driver
   always @(posedge clk) begin
      #1;
      if (rdy_rand) out_ready = ($urandom_range(0, 2) != 0);
      else          out_ready = rdy_val;
   end

   // Monitor: latency, output hold while stalled, and scoreboard pops on handshake
   bit           prev_ov = 1'b0;
   bit           prev_hs = 1'b0;
   logic [127:0] prev_pt = '0;
   always @(negedge clk) begin
      if (!rst_n) begin
         prev_ov = 1'b0;
         prev_hs = 1'b0;
      end else begin
         if (in_valid && in_ready) begin
            acc_q.push_back(cyc);
            acc_hist.push_back(cyc);
         end
         if (prev_ov && !prev_hs) chk("out_valid_hold", 128'(out_valid), 128'(1));
         if (out_valid) begin
            chk("in_ready_in_done", 128'(in_ready), 128'(0));
            chk("busy_in_done", 128'(busy), 128'(0));
            if (prev_ov && !prev_hs) chk("pt_hold", pt, prev_pt);
            if (!prev_ov) begin
               if (acc_q.size() > 0) chk("latency", 128'(cyc - acc_q.pop_front() - 1), 128'(20));
               else tmo("unexpected_output");
            end
            if (out_ready) begin
               if (exp_q.size() > 0) chk("pt", pt, exp_q.pop_front());
               else tmo("scoreboard_empty");
            end
         end
         prev_ov = out_valid;
         prev_hs = out_valid && out_ready;
         prev_pt = pt;
      end
   end

   task automatic send(input logic [127:0] k, input logic [127:0] c, input logic [127:0] e,
                       input bit hold);
      bit got;
      got = 1'b0;
      key = k;
      ct = c;
      in_valid = 1'b1;
      for (int i = 0; i < 200 && !got; i++) begin
         @(negedge clk);
         if (in_ready) begin
            exp_q.push_back(e);
            got = 1'b1;
         end
         @(posedge clk);
         #1;
      end
      if (!hold) in_valid = 1'b0;
      if (!got) tmo("accept");
   endtask

   task automatic wait_idle();
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 400 && !ok; i++) begin
         @(negedge clk);
         if (exp_q.size() == 0 && in_ready) ok = 1'b1;
      end
      if (!ok) tmo("drain");
      @(posedge clk);
      #1;
   endtask

   task automatic check_idle_outputs(input string tag);
      chk({tag, "_out_valid"}, 128'(out_valid), 128'(0));
      chk({tag, "_busy"}, 128'(busy), 128'(0));
      chk({tag, "_in_ready"}, 128'(in_ready), 128'(1));
      chk({tag, "_pt"}, pt, 128'(0));
   endtask

   initial begin
      logic [127:0] rk, rc, re;
      bit seen;
      build_tables();
      rst_n = 1'b0;
      in_valid = 1'b0;
      key = '0;
      ct = '0;
      repeat (3) @(posedge clk);
      #1;
      check_idle_outputs("reset");
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Known-answer vectors
      send(K1, C1, P1, 1'b0);
      wait_idle();
      send(K2, C2, P2, 1'b0);
      wait_idle();

      // Output stall with zero key
      rdy_val = 1'b0;
      send('0, C3, '0, 1'b0);
      seen = 1'b0;
      for (int i = 0; i < 60 && !seen; i++) begin
         @(negedge clk);
         if (out_valid) seen = 1'b1;
      end
      if (!seen) tmo("stall_out_valid");
      repeat (5) @(negedge clk);
      chk("stall_still_valid", 128'(out_valid), 128'(1));
      rdy_val = 1'b1;
      wait_idle();

      // Back-to-back with in_valid and out_ready held high
      send(K1, C1, P1, 1'b1);
      send(K2, C2, P2, 1'b1);
      in_valid = 1'b0;
      wait_idle();
      if (acc_hist.size() >= 2)
         chk("b2b_period", 128'(acc_hist[acc_hist.size()-1] - acc_hist[acc_hist.size()-2]), 128'(22));
      else tmo("b2b_accepts");

      // Input noise while busy must be ignored
      send(K2, C2, P2, 1'b0);
      for (int i = 0; i < 18; i++) begin
         key = {$urandom, $urandom, $urandom, $urandom};
         ct = {$urandom, $urandom, $urandom, $urandom};
         in_valid = $urandom_range(0, 1) != 0;
         @(negedge clk);
         chk("busy_no_accept", 128'(in_ready), 128'(0));
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
      wait_idle();

      // Asynchronous reset mid-ROUND
      send(K1, C1, P1, 1'b0);
      repeat (15) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      check_idle_outputs("midreset");
      exp_q.delete();
      acc_q.delete();
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      send(K1, C1, P1, 1'b0);
      wait_idle();

      // Random blocks against the reference model with random backpressure
      rdy_rand = 1'b1;
      for (int n = 0; n < 6; n++) begin
         rk = {$urandom, $urandom, $urandom, $urandom};
         rc = {$urandom, $urandom, $urandom, $urandom};
         re = ref_decrypt(rk, rc);
         send(rk, rc, re, 1'b0);
      end
      wait_idle();
      rdy_rand = 1'b0;
      repeat (3) @(posedge clk);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
